// File: rtl/audio_pwm_dac_if.sv
// Sample handshake between the tone generator (master) and the PWM DAC (slave).
interface audio_pwm_dac_if #(
    parameter int unsigned width = 7
) ();
    logic [width-1:0] sample_in;
    logic             sample_valid;
    logic             sample_ready;

    modport master (output sample_in, output sample_valid, input sample_ready);
    modport slave  (input sample_in, input sample_valid, output sample_ready);
endinterface

// File: rtl/audio_pwm_dac.sv
// Audio PWM DAC: single-entry sample buffer, 5-bit gain, glitch-free PWM with period 2^width.
// Optional AUDIO_PWM_SOFTMUTE_EN ramps the gain one step per period instead of jumping.
module audio_pwm_dac #(
    parameter int unsigned width = 7
) (
    input  logic              clk,
    input  logic              reset_n,
    audio_pwm_dac_if.slave    bus,
    input  logic [4:0]        volume,
    input  logic              mute,
    output logic              pwm_out,
    output logic [7:0]        underrun_cnt
);

    localparam int unsigned G_W    = 5;
    localparam int unsigned PROD_W = width + G_W;
    localparam int unsigned UND_W  = 8;

    localparam logic [G_W-1:0]   G_UNITY   = G_W'(16);
    localparam logic [width-1:0] CNT_MAX   = {width{1'b1}};
    localparam logic [width-1:0] DUTY_MID  = {1'b1, {(width-1){1'b0}}};
    localparam logic [width-1:0] LEVEL_MAX = {1'b0, {(width-1){1'b1}}};
    localparam logic [width-1:0] LEVEL_MIN = {1'b1, {(width-1){1'b0}}};
    localparam logic [UND_W-1:0] UND_MAX   = {UND_W{1'b1}};

    logic [width-1:0]        pwm_cnt;
    logic [width-1:0]        duty;
    logic [width-1:0]        hold_reg;
    logic                    hold_empty;
    logic [G_W-1:0]          g;

    logic                    boundary_c;
    logic                    accept_c;
    logic [G_W-1:0]          g_target_c;
    logic [G_W-1:0]          g_next_c;
    logic signed [PROD_W-1:0] prod_c;
    logic signed [PROD_W-1:0] scaled_c;
    logic [G_W:0]            scaled_top_c;
    logic [width-1:0]        level_c;
    logic [width-1:0]        duty_next_c;

    // Ready comes straight from the buffer-empty flop.
    assign bus.sample_ready = hold_empty;

    always_comb begin
        boundary_c = (pwm_cnt == CNT_MAX);
        accept_c   = bus.sample_valid && hold_empty;
    end

    // Gain target and per-boundary gain step.
    always_comb begin
        g_target_c = '0;
        g_next_c   = g;
        if (!mute) begin
            g_target_c = (volume > G_UNITY) ? G_UNITY : volume;
        end
`ifdef AUDIO_PWM_SOFTMUTE_EN
        if (g < g_target_c) begin
            g_next_c = g + G_W'(1);
        end else if (g > g_target_c) begin
            g_next_c = g - G_W'(1);
        end
`else
        g_next_c = g_target_c;
`endif
    end

    // Scale by g/16 (floor), saturate to width bits, then offset to unsigned duty.
    always_comb begin
        prod_c       = $signed({{G_W{hold_reg[width-1]}}, hold_reg}) *
                       $signed({{width{1'b0}}, g});
        scaled_c     = prod_c >>> 4;
        scaled_top_c = scaled_c[PROD_W-1:width-1];
        level_c      = scaled_c[width-1:0];
        if (!((scaled_top_c == '0) || (scaled_top_c == '1))) begin
            level_c = scaled_c[PROD_W-1] ? LEVEL_MIN : LEVEL_MAX;
        end
        duty_next_c = {~level_c[width-1], level_c[width-2:0]};
    end

    // Free-running period counter and registered compare.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pwm_cnt <= '0;
            pwm_out <= 1'b0;
        end else begin
            pwm_cnt <= pwm_cnt + width'(1);
            pwm_out <= (pwm_cnt < duty);
        end
    end

    // Single-entry holding buffer; a write at an empty boundary is kept for the next one.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hold_reg   <= '0;
            hold_empty <= 1'b1;
        end else if (accept_c) begin
            hold_reg   <= bus.sample_in;
            hold_empty <= 1'b0;
        end else if (boundary_c && !hold_empty) begin
            hold_empty <= 1'b1;
        end
    end

    // Period-boundary updates: duty load (old gain), gain step, underrun count.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            duty         <= DUTY_MID;
            g            <= '0;
            underrun_cnt <= '0;
        end else if (boundary_c) begin
            g <= g_next_c;
            if (!hold_empty) begin
                duty <= duty_next_c;
            end else if (underrun_cnt != UND_MAX) begin
                underrun_cnt <= underrun_cnt + UND_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_audio_pwm_dac.sv
// Directed bench for audio_pwm_dac at width 7 (128-clock period).
module tb_audio_pwm_dac;

    localparam int unsigned W   = 7;
    localparam int          PER = 128;
`ifdef AUDIO_PWM_SOFTMUTE_EN
    localparam int SETTLE = 16;
    localparam int MUTE_N = 18;
`else
    localparam int SETTLE = 1;
    localparam int MUTE_N = 4;
`endif

    typedef struct {
        logic signed [W-1:0] sample;
        logic [4:0]          volume;
        logic                mute;
        int                  exp_duty;
    } vec_t;

    logic       clk;
    logic       reset_n;
    logic [4:0] volume;
    logic       mute;
    logic       pwm_out;
    logic [7:0] underrun_cnt;

    int n_tests;
    int n_fail;
    bit tb_full;
    int exp_under;

    audio_pwm_dac_if #(.width(W)) bus ();

    audio_pwm_dac #(.width(W)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .bus          (bus),
        .volume       (volume),
        .mute         (mute),
        .pwm_out      (pwm_out),
        .underrun_cnt (underrun_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Holds reset for two edges, checks reset outputs, releases just after an edge.
    task automatic do_reset(input string tag);
        bus.sample_valid = 1'b0;
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check({tag, " pwm_out"}, 32'(pwm_out), 32'd0);
        check({tag, " ready"}, 32'(bus.sample_ready), 32'd1);
        check({tag, " underrun"}, 32'(underrun_cnt), 32'd0);
        reset_n   = 1'b1;
        tb_full   = 1'b0;
        exp_under = 0;
    endtask

    // One full period from just after a boundary to just after the next; counts high bits.
    task automatic period(input bit push, input logic signed [W-1:0] s, output int highs);
        highs = 0;
        for (int i = 0; i < PER; i++) begin
            if (i == 0 && push) begin
                bus.sample_valid = 1'b1;
                bus.sample_in    = s;
                tb_full          = 1'b1;
            end
            tick();
            bus.sample_valid = 1'b0;
            highs += int'(pwm_out);
        end
        if (tb_full) tb_full = 1'b0;
        else if (exp_under < 255) exp_under++;
    endtask

    function automatic int mute_exp(input int k);
        int gk;
`ifdef AUDIO_PWM_SOFTMUTE_EN
        gk = 16 - (k - 1);
        if (gk < 0) gk = 0;
`else
        gk = (k == 1) ? 16 : 0;
`endif
        return ((63 * gk) >>> 4) + 64;
    endfunction

    vec_t vecs[10];

    initial begin
        int h;
        int ready_hi;
        n_tests = 0;
        n_fail  = 0;
        tb_full = 1'b0;
        exp_under = 0;
        reset_n = 1'b0;
        volume  = 5'd16;
        mute    = 1'b0;
        bus.sample_valid = 1'b0;
        bus.sample_in    = '0;

        vecs[0] = '{7'sd0,   5'd16, 1'b0, 64};
        vecs[1] = '{7'sd63,  5'd8,  1'b0, 95};
        vecs[2] = '{-7'sd64, 5'd16, 1'b0, 0};
        vecs[3] = '{7'sd63,  5'd20, 1'b0, 127};
        vecs[4] = '{-7'sd1,  5'd8,  1'b0, 63};
        vecs[5] = '{-7'sd64, 5'd1,  1'b0, 60};
        vecs[6] = '{7'sd37,  5'd3,  1'b0, 70};
        vecs[7] = '{7'sd50,  5'd16, 1'b1, 64};
        vecs[8] = '{7'sd63,  5'd0,  1'b0, 64};
        vecs[9] = '{7'sd63,  5'd31, 1'b0, 127};

        do_reset("reset0");

        // Mid-scale: sample 0 every period.
        for (int p = 0; p < 4; p++) begin
            period(1'b1, 7'sd0, h);
            check($sformatf("midscale p%0d highs", p), 32'(h), 32'd64);
        end
        check("midscale underrun", 32'(underrun_cnt), 32'd0);

        // Gain table: settle gain, load sample, measure the following period.
        foreach (vecs[i]) begin
            volume = vecs[i].volume;
            mute   = vecs[i].mute;
            repeat (SETTLE) period(1'b0, '0, h);
            period(1'b1, vecs[i].sample, h);
            period(1'b0, '0, h);
            check($sformatf("vec%0d duty", i), 32'(h), 32'(vecs[i].exp_duty));
        end
        check("table underrun", 32'(underrun_cnt), 32'(exp_under));

        // Underrun: last level repeats.
        for (int p = 0; p < 3; p++) begin
            period(1'b0, '0, h);
            check($sformatf("hold p%0d highs", p), 32'(h), 32'd127);
        end
        check("hold underrun", 32'(underrun_cnt), 32'(exp_under));

        // Backpressure: second sample waits for the boundary.
        volume = 5'd16;
        mute   = 1'b0;
        repeat (SETTLE) period(1'b0, '0, h);
        bus.sample_valid = 1'b1;
        bus.sample_in    = 7'sd10;
        tick();
        bus.sample_in = -7'sd20;
        check("bp ready after accept", 32'(bus.sample_ready), 32'd0);
        ready_hi = 0;
        for (int i = 2; i < PER; i++) begin
            tick();
            ready_hi += int'(bus.sample_ready);
        end
        check("bp ready low in period", 32'(ready_hi), 32'd0);
        tick();
        check("bp ready after boundary", 32'(bus.sample_ready), 32'd1);
        tick();
        check("bp second accepted", 32'(bus.sample_ready), 32'd0);
        bus.sample_valid = 1'b0;
        h = int'(pwm_out);
        for (int i = 1; i < PER; i++) begin
            tick();
            h += int'(pwm_out);
        end
        check("bp first duty", 32'(h), 32'd74);
        period(1'b0, '0, h);
        check("bp second duty", 32'(h), 32'd44);

        // Mute with sample 63 streaming at unity gain.
        mute = 1'b1;
        for (int k = 0; k < MUTE_N; k++) begin
            period(1'b1, 7'sd63, h);
            if (k >= 1) check($sformatf("mute k%0d duty", k), 32'(h), 32'(mute_exp(k)));
        end
        check("mute underrun", 32'(underrun_cnt), 32'(exp_under));
        mute = 1'b0;

        // Underrun counting and saturation from reset.
        do_reset("reset1");
        for (int p = 0; p < 3; p++) period(1'b0, '0, h);
        check("underrun 3", 32'(underrun_cnt), 32'd3);
        check("underrun held duty", 32'(h), 32'd64);
        repeat (300 * PER) tick();
        check("underrun sat", 32'(underrun_cnt), 32'd255);

        // Reset mid-period with the buffer full.
        bus.sample_valid = 1'b1;
        bus.sample_in    = 7'sd63;
        tick();
        bus.sample_valid = 1'b0;
        repeat (39) tick();
        check("pre-reset pwm_out", 32'(pwm_out), 32'd1);
        check("pre-reset ready", 32'(bus.sample_ready), 32'd0);
        reset_n = 1'b0;
        #1;
        check("async pwm_out", 32'(pwm_out), 32'd0);
        check("async ready", 32'(bus.sample_ready), 32'd1);
        check("async underrun", 32'(underrun_cnt), 32'd0);
        do_reset("reset2");
        period(1'b0, '0, h);
        check("post-reset duty", 32'(h), 32'd64);
        check("post-reset discard", 32'(underrun_cnt), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
